// File: rtl/operand_b_sel_ctrl.sv
// Decode-stage operand-B select controller: registers the ID/EX operand-B select, detects
// load-use hazards with a one-cycle RUN/STALL FSM, and drives the EX-stage rs2 forwarding select.
module operand_b_sel_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            if_id_instr,
    input  logic                   if_id_valid,
    input  logic                   ex_flush,
    input  logic                   ex_mem_reg_write,
    input  logic [4:0]             ex_mem_rd,
    input  logic                   mem_wb_reg_write,
    input  logic [4:0]             mem_wb_rd,
    output logic [1:0]             id_ex_read_data_2_sel,
    output logic                   id_ex_mem_read,
    output logic [1:0]             fwd_b_sel,
    output logic                   stall_if_id,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   fsm_state
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t     state;
    logic [4:0] id_ex_rs2;
    logic [4:0] id_ex_rd;
    logic       id_ex_store;

    logic [6:0] opcode;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [4:0] dec_rd;
    logic [1:0] dec_sel;
    logic       dec_load;
    logic       dec_store;
    logic       rs1_used;
    logic       rs2_used;
    logic       hazard;
    logic       fwd_active;

    always_comb begin
        opcode    = if_id_instr[6:0];
        dec_rs1   = if_id_instr[19:15];
        dec_rs2   = if_id_valid ? if_id_instr[24:20] : 5'd0;
        dec_rd    = if_id_valid ? if_id_instr[11:7] : 5'd0;
        dec_sel   = 2'b00;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        case (opcode)
            OP_R, OP_BRANCH: begin
                dec_sel  = 2'b01;
                rs2_used = 1'b1;
            end
            OP_LOAD: begin
                dec_sel  = 2'b10;
                dec_load = 1'b1;
            end
            OP_STORE: begin
                dec_sel   = 2'b10;
                dec_store = 1'b1;
                rs2_used  = 1'b1;
            end
            OP_IMM, OP_JALR: dec_sel = 2'b10;
            OP_LUI, OP_AUIPC, OP_JAL: rs1_used = 1'b0;
            default: ;
        endcase
        if (!if_id_valid) begin
            dec_sel   = 2'b00;
            dec_load  = 1'b0;
            dec_store = 1'b0;
        end
    end

    // The STALL cycle already has the bubble in ID/EX, so the hazard cannot re-fire.
    assign hazard = (state == RUN) && id_ex_mem_read && (id_ex_rd != 5'd0) && if_id_valid &&
                    ((rs1_used && (dec_rs1 == id_ex_rd)) || (rs2_used && (dec_rs2 == id_ex_rd)));

    assign stall_if_id = hazard && !ex_flush;
    assign fsm_state   = (state == STALL);

    assign fwd_active = (id_ex_read_data_2_sel == 2'b01) || id_ex_store;

    always_comb begin
        fwd_b_sel = 2'b00;
        if (fwd_active && (id_ex_rs2 != 5'd0)) begin
            if (ex_mem_reg_write && (ex_mem_rd == id_ex_rs2)) begin
                fwd_b_sel = 2'b10;
            end else if (mem_wb_reg_write && (mem_wb_rd == id_ex_rs2)) begin
                fwd_b_sel = 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= RUN;
            id_ex_read_data_2_sel <= 2'b00;
            id_ex_mem_read        <= 1'b0;
            id_ex_rs2             <= 5'd0;
            id_ex_rd              <= 5'd0;
            id_ex_store           <= 1'b0;
            stall_count           <= '0;
        end else if (ex_flush || hazard) begin
            id_ex_read_data_2_sel <= 2'b00;
            id_ex_mem_read        <= 1'b0;
            id_ex_rs2             <= 5'd0;
            id_ex_rd              <= 5'd0;
            id_ex_store           <= 1'b0;
            if (ex_flush) begin
                state <= RUN;
            end else begin
                state <= STALL;
                if (stall_count != '1) begin
                    stall_count <= stall_count + 1'b1;
                end
            end
        end else begin
            state                 <= RUN;
            id_ex_read_data_2_sel <= dec_sel;
            id_ex_mem_read        <= dec_load;
            id_ex_rs2             <= dec_rs2;
            id_ex_rd              <= dec_rd;
            id_ex_store           <= dec_store;
        end
    end

endmodule

// File: tb/tb_operand_b_sel_ctrl.sv
// Bench for operand_b_sel_ctrl: directed scenarios plus random traffic checked against an
// instruction-level pipeline model; a second instance with a 2-bit counter covers saturation.
module tb_operand_b_sel_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        ex_flush;
    logic        ex_mem_reg_write;
    logic [4:0]  ex_mem_rd;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_rd;

    logic [1:0]  sel_a, fwd_a, sel_b, fwd_b;
    logic        mr_a, stall_a, st_a, mr_b, stall_b, st_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    operand_b_sel_ctrl #(.STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .ex_flush(ex_flush), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
        .id_ex_read_data_2_sel(sel_a), .id_ex_mem_read(mr_a), .fwd_b_sel(fwd_a),
        .stall_if_id(stall_a), .stall_count(cnt_a), .fsm_state(st_a)
    );

    operand_b_sel_ctrl #(.STALL_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .ex_flush(ex_flush), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
        .id_ex_read_data_2_sel(sel_b), .id_ex_mem_read(mr_b), .fwd_b_sel(fwd_b),
        .stall_if_id(stall_b), .stall_count(cnt_b), .fsm_state(st_b)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Model: ID/EX holds a whole instruction (or a bubble); everything is decoded on demand.
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_stalled;
    int          m_count;
    logic        m_known = 1'b0;
    logic        last_stall;
    logic [1:0]  last_fwd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] sel_of(input logic [31:0] ins, input logic v);
        if (!v) return 2'b00;
        case (ins[6:0])
            7'b0110011, 7'b1100011: return 2'b01;
            7'b0000011, 7'b0010011, 7'b0100011, 7'b1100111: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [31:0] ins);
        return !(ins[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ins);
        return ins[6:0] inside {7'b0110011, 7'b1100011, 7'b0100011};
    endfunction

    function automatic logic m_hazard();
        logic [4:0] rd;
        rd = m_instr[11:7];
        if (m_stalled || !m_valid || m_instr[6:0] != 7'b0000011 || rd == 5'd0 || !if_id_valid)
            return 1'b0;
        return (uses_rs1(if_id_instr) && if_id_instr[19:15] == rd) ||
               (uses_rs2(if_id_instr) && if_id_instr[24:20] == rd);
    endfunction

    function automatic logic [1:0] m_fwd();
        logic [4:0] rs2;
        rs2 = m_instr[24:20];
        if (!m_valid || rs2 == 5'd0) return 2'b00;
        if (!(sel_of(m_instr, 1'b1) == 2'b01 || m_instr[6:0] == 7'b0100011)) return 2'b00;
        if (ex_mem_reg_write && ex_mem_rd == rs2) return 2'b10;
        if (mem_wb_reg_write && mem_wb_rd == rs2) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step(input logic r, input logic [31:0] ins, input logic v, input logic fl,
                        input logic ew, input logic [4:0] er, input logic mw, input logic [4:0] mr);
        logic hz;
        logic [1:0] efwd;
        int exp_a, exp_b;
        @(negedge clk);
        rst = r; if_id_instr = ins; if_id_valid = v; ex_flush = fl;
        ex_mem_reg_write = ew; ex_mem_rd = er; mem_wb_reg_write = mw; mem_wb_rd = mr;
        #1;
        hz   = m_known && m_hazard();
        efwd = m_fwd();
        if (m_known) begin
            check_eq("stall_if_id", stall_a, hz && !fl);
            check_eq("stall_if_id_w2", stall_b, hz && !fl);
            check_eq("fwd_b_sel", fwd_a, efwd);
            check_eq("fwd_b_sel_w2", fwd_b, efwd);
        end
        last_stall = stall_a;
        last_fwd   = fwd_a;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_instr = '0; m_stalled = 1'b0; m_count = 0; m_known = 1'b1;
        end else if (fl) begin
            m_valid = 1'b0; m_stalled = 1'b0;
        end else if (hz) begin
            m_valid = 1'b0; m_stalled = 1'b1; m_count++;
        end else begin
            m_valid = v; m_instr = ins; m_stalled = 1'b0;
        end
        #1;
        if (m_known) begin
            exp_a = (m_count > 65535) ? 65535 : m_count;
            exp_b = (m_count > 3) ? 3 : m_count;
            check_eq("sel", sel_a, sel_of(m_instr, m_valid));
            check_eq("sel_w2", sel_b, sel_of(m_instr, m_valid));
            check_eq("mem_read", mr_a, m_valid && m_instr[6:0] == 7'b0000011);
            check_eq("mem_read_w2", mr_b, m_valid && m_instr[6:0] == 7'b0000011);
            check_eq("stall_count", cnt_a, exp_a);
            check_eq("stall_count_w2", cnt_b, exp_b);
            check_eq("state", st_a, m_stalled);
            check_eq("state_w2", st_b, m_stalled);
        end
    endtask

    task automatic run(input logic [31:0] ins);
        step(1'b0, ins, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs2, rs1);
        return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
    endfunction

    logic [6:0]  ops [10];
    logic [31:0] cur_ins;
    logic        cur_v;

    initial begin
        ops = '{7'b0110011, 7'b1100011, 7'b0000011, 7'b0010011, 7'b0100011,
                7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};

        // T1: reset held two cycles with a valid R-type present
        repeat (2) begin
            step(1'b1, enc_r(5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
            check_eq("t1_sel", sel_a, 2'b00);
            check_eq("t1_stall", stall_a, 1'b0);
            check_eq("t1_count", cnt_a, 0);
        end
        run(enc_r(5'd3, 5'd1, 5'd2));
        check_eq("t1_sel_after", sel_a, 2'b01);

        // T2: decode
        run(enc_r(5'd3, 5'd1, 5'd2));              check_eq("t2_add", sel_a, 2'b01);
        run(enc_i(7'b0010011, 5'd4, 5'd1, 12'd5)); check_eq("t2_addi", sel_a, 2'b10);
        run(enc_s(5'd2, 5'd1));                    check_eq("t2_sw", sel_a, 2'b10);
        run({20'h1, 5'd5, 7'b0110111});            check_eq("t2_lui", sel_a, 2'b00);

        // T3: load-use stall, then the x0 case
        do_reset();
        run(enc_i(7'b0000011, 5'd6, 5'd1, 12'd0));
        run(enc_r(5'd7, 5'd6, 5'd2));
        check_eq("t3_stall", last_stall, 1'b1);
        check_eq("t3_bubble", sel_a, 2'b00);
        check_eq("t3_count", cnt_a, 1);
        run(enc_r(5'd7, 5'd6, 5'd2));
        check_eq("t3_stall_gone", last_stall, 1'b0);
        check_eq("t3_sel", sel_a, 2'b01);
        run(enc_i(7'b0000011, 5'd0, 5'd1, 12'd0));
        run(enc_r(5'd7, 5'd0, 5'd2));
        check_eq("t3_x0_stall", last_stall, 1'b0);
        check_eq("t3_x0_sel", sel_a, 2'b01);

        // T4: forwarding priority with add rs2=x5 held in ID/EX
        run(enc_r(5'd1, 5'd3, 5'd5));
        step(1'b0, enc_r(5'd1, 5'd3, 5'd5), 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5);
        check_eq("t4_exmem", last_fwd, 2'b10);
        step(1'b0, enc_r(5'd1, 5'd3, 5'd5), 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5);
        check_eq("t4_memwb", last_fwd, 2'b01);
        step(1'b0, enc_r(5'd1, 5'd3, 5'd5), 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
        check_eq("t4_none", last_fwd, 2'b00);

        // T5: flush with the hazard present
        do_reset();
        run(enc_i(7'b0000011, 5'd6, 5'd1, 12'd0));
        step(1'b0, enc_r(5'd7, 5'd6, 5'd2), 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        check_eq("t5_stall", last_stall, 1'b0);
        check_eq("t5_bubble", sel_a, 2'b00);
        check_eq("t5_count", cnt_a, 0);
        check_eq("t5_state", st_a, 1'b0);

        // Reset while in STALL
        run(enc_i(7'b0000011, 5'd6, 5'd1, 12'd0));
        run(enc_r(5'd7, 5'd6, 5'd2));
        check_eq("rst_in_stall_pre", st_a, 1'b1);
        step(1'b1, enc_r(5'd7, 5'd6, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        check_eq("rst_in_stall_state", st_a, 1'b0);
        check_eq("rst_in_stall_count", cnt_a, 0);

        // T6: saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            run(enc_i(7'b0000011, 5'd6, 5'd1, 12'd0));
            run(enc_r(5'd7, 5'd6, 5'd2));
            run(enc_r(5'd7, 5'd6, 5'd2));
            check_eq("t6_sat", cnt_b, (i < 3) ? i + 1 : 3);
        end

        // Random traffic; IF/ID holds whenever the model says the pipeline stalled
        do_reset();
        cur_ins = 32'h13;
        cur_v   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!m_stalled) begin
                cur_ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]};
                cur_v   = ($urandom_range(0, 7) != 0);
            end
            step(($urandom_range(0, 199) == 0), cur_ins, cur_v, ($urandom_range(0, 15) == 0),
                 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
